// File: rtl/rr_arbiter_onehot_if.sv
// rtl/rr_arbiter_onehot_if.sv - request/grant bundle for the round-robin arbiter
//
// Purpose: groups the requester-side handshake and the one-hot grant bus.
// Signals:
//   req        N  level request lines, held by each requester until served
//   done       1  owner releases the current grant (single-cycle pulse)
//   gnt        N  registered one-hot grant, all-zero when idle
//   gntValid   1  equals |gnt
//   timeoutErr 1  single-cycle pulse when the watchdog revokes a grant
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_onehot_if #(
  parameter int N = 8
) ();
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gntValid;
  logic         timeoutErr;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gntValid,
    input  timeoutErr
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gntValid,
    output timeoutErr
  );
endinterface

// File: rtl/rr_arbiter_onehot.sv
// rtl/rr_arbiter_onehot.sv - registered round-robin arbiter with one-hot grant and watchdog
//
// Purpose: grants one requester at a time, scanning from a rotating pointer,
// and holds the grant until done or until the watchdog expires (TIMEOUT
// cycles, 0 disables it). The last owner becomes lowest priority.
// Ports:
//   clk  1  rising-edge clock
//   rst  1  synchronous reset, active-high
//   bus  slave modport of rr_arbiter_onehot_if (req, done, gnt, gntValid, timeoutErr)
module rr_arbiter_onehot #(
  parameter int N       = 8,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  rr_arbiter_onehot_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          terr_q, terr_d;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] ptr_after;
  int            scan_j;

  // First set request at or above ptr, wrapping modulo N (N may be non power of 2).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_j     = 0;
    for (int k = 0; k < N; k++) begin
      scan_j = int'(ptr_q) + k;
      if (scan_j >= N) begin
        scan_j = scan_j - N;
      end
      if (!pick_found && bus.req[PW'(scan_j)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(scan_j);
      end
    end
  end

  // The owner drops to lowest priority once released.
  assign ptr_after = (own_q == PW'(N - 1)) ? '0 : own_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = BUSY;
          own_d   = pick_idx;
          cnt_d   = '0;
          gnt_d   = N'(1) << pick_idx;
        end
      end
      BUSY: begin
        // done takes priority over a simultaneous watchdog expiry.
        if (bus.done) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_after;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_after;
          terr_d  = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gntValid   = |gnt_q;
  assign bus.timeoutErr = terr_q;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// tb/tb_rr_arbiter_onehot.sv - directed self-checking bench for rr_arbiter_onehot
`timescale 1ns/1ps
module tb_rr_arbiter_onehot;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rr_arbiter_onehot_if #(.N(8)) bus_a ();
  rr_arbiter_onehot_if #(.N(8)) bus_b ();

  rr_arbiter_onehot #(.N(8), .TIMEOUT(255)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rr_arbiter_onehot #(.N(8), .TIMEOUT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus_a.req = 8'h00; bus_a.done = 1'b0;
    bus_b.req = 8'h00; bus_b.done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus_a.gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt_a: got %h expected 00", bus_a.gnt); end
    checks++; if (bus_a.gntValid !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", bus_a.gntValid); end
    checks++; if (bus_a.timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_terr_a: got %b expected 0", bus_a.timeoutErr); end
    checks++; if (bus_b.gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt_b: got %h expected 00", bus_b.gnt); end
    checks++; if (bus_b.timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_terr_b: got %b expected 0", bus_b.timeoutErr); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus_a.gnt !== 8'h00 || bus_a.gntValid !== 1'b0) begin errors++; $display("FAIL idle_no_req cycle %0d: gnt=%h valid=%b expected 00/0", c, bus_a.gnt, bus_a.gntValid); end
    end
    // done pulsed while idle must not move the pointer: req=03 still picks bit 0
    bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
    bus_a.req = 8'h03; tick();
    checks++; if (bus_a.gnt !== 8'h01) begin errors++; $display("FAIL idle_done_ignored: got %h expected 01", bus_a.gnt); end
  endtask

  task automatic test_wrap;
    do_reset();
    bus_a.req = 8'h81;
    tick();
    checks++; if (bus_a.gnt !== 8'h01 || bus_a.gntValid !== 1'b1) begin errors++; $display("FAIL wrap_first: gnt=%h valid=%b expected 01/1", bus_a.gnt, bus_a.gntValid); end
    bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
    checks++; if (bus_a.gnt !== 8'h00) begin errors++; $display("FAIL wrap_dead1: got %h expected 00", bus_a.gnt); end
    tick();
    checks++; if (bus_a.gnt !== 8'h80) begin errors++; $display("FAIL wrap_second: got %h expected 80", bus_a.gnt); end
    bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
    checks++; if (bus_a.gnt !== 8'h00) begin errors++; $display("FAIL wrap_dead2: got %h expected 00", bus_a.gnt); end
    tick();
    checks++; if (bus_a.gnt !== 8'h01) begin errors++; $display("FAIL wrap_third: got %h expected 01", bus_a.gnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    do_reset();
    bus_a.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp = 8'h01 << (k % 8);
      tick();
      checks++; if (bus_a.gnt !== exp) begin errors++; $display("FAIL rotate grant %0d: got %h expected %h", k, bus_a.gnt, exp); end
      checks++; if (!$onehot0(bus_a.gnt) || bus_a.gntValid !== (|bus_a.gnt)) begin errors++; $display("FAIL rotate onehot %0d: gnt=%h valid=%b", k, bus_a.gnt, bus_a.gntValid); end
      bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
      checks++; if (bus_a.gnt !== 8'h00 || bus_a.gntValid !== 1'b0) begin errors++; $display("FAIL rotate gap %0d: gnt=%h valid=%b expected 00/0", k, bus_a.gnt, bus_a.gntValid); end
    end
  endtask

  task automatic test_timeout;
    do_reset();
    bus_b.req = 8'h10;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus_b.gnt !== 8'h10 || bus_b.timeoutErr !== 1'b0) begin errors++; $display("FAIL timeout_hold cycle %0d: gnt=%h terr=%b expected 10/0", c, bus_b.gnt, bus_b.timeoutErr); end
      tick();
    end
    checks++; if (bus_b.gnt !== 8'h00 || bus_b.timeoutErr !== 1'b1) begin errors++; $display("FAIL timeout_revoke: gnt=%h terr=%b expected 00/1", bus_b.gnt, bus_b.timeoutErr); end
    tick();
    checks++; if (bus_b.gnt !== 8'h10 || bus_b.timeoutErr !== 1'b0) begin errors++; $display("FAIL timeout_regrant: gnt=%h terr=%b expected 10/0", bus_b.gnt, bus_b.timeoutErr); end
    bus_b.req = 8'h00;
    bus_b.done = 1'b1; tick(); bus_b.done = 1'b0;
  endtask

  task automatic test_done_vs_timeout;
    do_reset();
    bus_b.req = 8'h10;
    tick();
    tick(); tick(); tick();
    checks++; if (bus_b.gnt !== 8'h10) begin errors++; $display("FAIL expiry_hold: got %h expected 10", bus_b.gnt); end
    bus_b.done = 1'b1; tick(); bus_b.done = 1'b0;
    checks++; if (bus_b.gnt !== 8'h00 || bus_b.timeoutErr !== 1'b0) begin errors++; $display("FAIL done_wins: gnt=%h terr=%b expected 00/0", bus_b.gnt, bus_b.timeoutErr); end
    tick();
    checks++; if (bus_b.timeoutErr !== 1'b0) begin errors++; $display("FAIL done_wins_late: terr=%b expected 0", bus_b.timeoutErr); end
    bus_b.req = 8'h00;
  endtask

  task automatic test_req_drop;
    do_reset();
    bus_a.req = 8'h08;
    tick();
    bus_a.req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus_a.gnt !== 8'h08) begin errors++; $display("FAIL drop_hold cycle %0d: got %h expected 08", c, bus_a.gnt); end
    end
    bus_a.req = 8'h20;
    tick();
    checks++; if (bus_a.gnt !== 8'h08) begin errors++; $display("FAIL drop_other_req: got %h expected 08", bus_a.gnt); end
    bus_a.req = 8'h00;
    bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
    tick();
    checks++; if (bus_a.gnt !== 8'h00) begin errors++; $display("FAIL drop_release: got %h expected 00", bus_a.gnt); end
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    bus_a.req = 8'h01;
    tick();
    bus_a.req = 8'h04;
    bus_a.done = 1'b1; tick(); bus_a.done = 1'b0;
    tick();
    checks++; if (bus_a.gnt !== 8'h04) begin errors++; $display("FAIL mid_pre: got %h expected 04", bus_a.gnt); end
    rst = 1'b1;
    tick();
    checks++; if (bus_a.gnt !== 8'h00 || bus_a.gntValid !== 1'b0) begin errors++; $display("FAIL mid_reset: gnt=%h valid=%b expected 00/0", bus_a.gnt, bus_a.gntValid); end
    rst = 1'b0;
    bus_a.req = 8'h05;
    tick();
    checks++; if (bus_a.gnt !== 8'h01) begin errors++; $display("FAIL mid_ptr_cleared: got %h expected 01", bus_a.gnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_a.req = 8'h00; bus_a.done = 1'b0;
    bus_b.req = 8'h00; bus_b.done = 1'b0;
    test_reset();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_done_vs_timeout();
    test_req_drop();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
